// File: rtl/sync_counter_pkg.sv
// Shared types and next-value arithmetic for the sync_updown_counter family.
// Pure declarations: no state, no latency, no flow control.
package sync_counter_pkg;

  typedef enum logic {CNT_RUN, CNT_HALT} cnt_state_t;

  // 33-bit working width so a full 32-bit counter with MODULUS=2**32 still fits.
  function automatic logic [32:0] next_count(input logic [32:0] q,
                                             input logic        up,
                                             input logic [32:0] modulus);
    logic [32:0] res;
    if (up) begin
      res = (q >= modulus - 33'd1) ? 33'd0 : q + 33'd1;
    end else begin
      res = (q == 33'd0) ? modulus - 33'd1 : q - 33'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_tc_decode.sv
// Terminal-count decode: last value in the current direction (MODULUS-1 up, 0 down).
// Combinational, zero latency; no flow control.
module cnt_tc_decode
  import sync_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TC_UP = WIDTH'(MODULUS - 64'd1);

  assign tc = up ? (q == TC_UP) : (q == '0);

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with TTL-style ENP/ENT/clear/load, cascadable via _RCO; optional match port (SYNC_COUNTER_MATCH_EN).
// Latency: _Q/_DONE/_MATCH update one _CLK edge after controls are sampled; _RCO is combinational.
// No backpressure: an action is taken on every edge by fixed priority _RST > _CLR > _LOAD > count > hold.
module sync_updown_counter
  import sync_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter longint unsigned  MODULUS   = 64'd1 << WIDTH,
  parameter bit               ONESHOT   = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             _CLK,
  input  logic             _RST,
  input  logic             _CLR,
  input  logic             _LOAD,
  input  logic             _ENP,
  input  logic             _ENT,
  input  logic             _UP,
  input  logic [WIDTH-1:0] _D,
  output logic [WIDTH-1:0] _Q,
  output logic             _RCO,
  output logic             _DONE
`ifdef SYNC_COUNTER_MATCH_EN
  ,
  input  logic [WIDTH-1:0] _MATCH_VAL,
  output logic             _MATCH
`endif
);

  localparam logic [32:0] MOD_W = 33'(MODULUS);

  cnt_state_t       state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt, q_step;
  logic             tc, halted, count_en, done;

  cnt_tc_decode #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_tc (
    .q (q),
    .up(_UP),
    .tc(tc)
  );

  assign halted   = (state == CNT_HALT);
  assign count_en = _ENP & _ENT & ~halted;
  assign q_step   = WIDTH'(next_count(33'(q), _UP, MOD_W));

  always_comb begin
    q_nxt     = q;
    state_nxt = state;
    if (!_CLR) begin
      q_nxt     = '0;
      state_nxt = CNT_RUN;
    end else if (!_LOAD) begin
      q_nxt     = _D;
      state_nxt = CNT_RUN;
    end else if (count_en) begin
      // One-shot parks on the terminal value instead of wrapping.
      if (ONESHOT && tc) begin
        state_nxt = CNT_HALT;
      end else begin
        q_nxt = q_step;
      end
    end
  end

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      q     <= RESET_VAL;
      state <= CNT_RUN;
      done  <= 1'b0;
    end else begin
      q     <= q_nxt;
      state <= state_nxt;
      done  <= (state_nxt == CNT_HALT);
    end
  end

  assign _Q    = q;
  assign _DONE = done;
  assign _RCO  = _ENT & tc & ~halted;

`ifdef SYNC_COUNTER_MATCH_EN
  logic q_upd, match_q;

  // Only edges that actually write _Q can raise a match; holds and the halt edge cannot.
  assign q_upd = ~_CLR | ~_LOAD | (count_en & ~(ONESHOT & tc));

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      match_q <= 1'b0;
    end else begin
      match_q <= q_upd & (q_nxt == _MATCH_VAL);
    end
  end

  assign _MATCH = match_q;
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: mod-10 up/down instance, mod-16 one-shot instance, 2x4-bit cascade.
module tb_sync_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: WIDTH=4, MODULUS=10, RESET_VAL=5, free-running
  logic       a_rst, a_clr, a_load, a_enp, a_ent, a_up;
  logic [3:0] a_d, a_q;
  logic       a_rco, a_done;
  // Instance B: WIDTH=4, MODULUS=16, one-shot
  logic       b_rst, b_clr, b_load, b_enp, b_ent, b_up;
  logic [3:0] b_d, b_q;
  logic       b_rco, b_done;
  // Cascade C: two 4-bit stages, low RCO feeds high ENT
  logic       c_rst, c_clr, c_load, c_en;
  logic [7:0] c_d;
  logic [3:0] c_lo_q, c_hi_q;
  logic       c_lo_rco, c_hi_rco, c_lo_done, c_hi_done;
`ifdef SYNC_COUNTER_MATCH_EN
  logic [3:0] a_mv, b_mv;
  logic       a_match, b_match, c_lo_match, c_hi_match;
`endif

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0), .RESET_VAL(4'd5)) dut_a (
    ._CLK(clk), ._RST(a_rst), ._CLR(a_clr), ._LOAD(a_load), ._ENP(a_enp), ._ENT(a_ent),
    ._UP(a_up), ._D(a_d), ._Q(a_q), ._RCO(a_rco), ._DONE(a_done)
`ifdef SYNC_COUNTER_MATCH_EN
    , ._MATCH_VAL(a_mv), ._MATCH(a_match)
`endif
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(1'b1), .RESET_VAL(4'd0)) dut_b (
    ._CLK(clk), ._RST(b_rst), ._CLR(b_clr), ._LOAD(b_load), ._ENP(b_enp), ._ENT(b_ent),
    ._UP(b_up), ._D(b_d), ._Q(b_q), ._RCO(b_rco), ._DONE(b_done)
`ifdef SYNC_COUNTER_MATCH_EN
    , ._MATCH_VAL(b_mv), ._MATCH(b_match)
`endif
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(1'b0), .RESET_VAL(4'd0)) dut_c_lo (
    ._CLK(clk), ._RST(c_rst), ._CLR(c_clr), ._LOAD(c_load), ._ENP(1'b1), ._ENT(c_en),
    ._UP(1'b1), ._D(c_d[3:0]), ._Q(c_lo_q), ._RCO(c_lo_rco), ._DONE(c_lo_done)
`ifdef SYNC_COUNTER_MATCH_EN
    , ._MATCH_VAL(4'd0), ._MATCH(c_lo_match)
`endif
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(1'b0), .RESET_VAL(4'd0)) dut_c_hi (
    ._CLK(clk), ._RST(c_rst), ._CLR(c_clr), ._LOAD(c_load), ._ENP(1'b1), ._ENT(c_lo_rco),
    ._UP(1'b1), ._D(c_d[7:4]), ._Q(c_hi_q), ._RCO(c_hi_rco), ._DONE(c_hi_done)
`ifdef SYNC_COUNTER_MATCH_EN
    , ._MATCH_VAL(4'd0), ._MATCH(c_hi_match)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int q;
    bit halted;
    bit match;
  } ms_t;

  function automatic bit mtc(input int q, input bit up, input int m);
    return up ? (q == m - 1) : (q == 0);
  endfunction

  function automatic ms_t mstep(input ms_t s, input int m, input int rv, input bit os,
                                input bit rst, input bit clr, input bit load, input bit enp,
                                input bit ent, input bit up, input int d, input int mv);
    ms_t r;
    r = s;
    r.match = 1'b0;
    if (rst) begin
      r.q = rv;
      r.halted = 1'b0;
    end else if (!clr) begin
      r.q = 0;
      r.halted = 1'b0;
      r.match = (mv == 0);
    end else if (!load) begin
      r.q = d;
      r.halted = 1'b0;
      r.match = (d == mv);
    end else if (enp && ent && !s.halted) begin
      if (os && mtc(s.q, up, m)) begin
        r.halted = 1'b1;
      end else begin
        if (up) r.q = (s.q >= m - 1) ? 0 : s.q + 1;
        else    r.q = (s.q == 0) ? m - 1 : s.q - 1;
        r.match = (r.q == mv);
      end
    end
    return r;
  endfunction

  ms_t ma, mb;
  int  mc;
  bit  va = 1'b0, vb = 1'b0, vc = 1'b0;
  int  amv, bmv;

  initial begin
    ma = '{q: 0, halted: 1'b0, match: 1'b0};
    mb = '{q: 0, halted: 1'b0, match: 1'b0};
    mc = 0;
    forever begin
      @(posedge clk);
`ifdef SYNC_COUNTER_MATCH_EN
      amv = int'(a_mv);
      bmv = int'(b_mv);
`else
      amv = -1;
      bmv = -1;
`endif
      if (a_rst) va = 1'b1;
      if (b_rst) vb = 1'b1;
      if (c_rst) vc = 1'b1;
      ma = mstep(ma, 10, 5, 1'b0, a_rst, a_clr, a_load, a_enp, a_ent, a_up, int'(a_d), amv);
      mb = mstep(mb, 16, 0, 1'b1, b_rst, b_clr, b_load, b_enp, b_ent, b_up, int'(b_d), bmv);
      if (c_rst || !c_clr) mc = 0;
      else if (!c_load)    mc = int'(c_d);
      else if (c_en)       mc = (mc + 1) % 256;
      #1;
      if (va) begin
        chk("a_q",    32'(a_q),    32'(ma.q));
        chk("a_rco",  32'(a_rco),  32'(a_ent && mtc(ma.q, a_up, 10) && !ma.halted));
        chk("a_done", 32'(a_done), 32'(0));
`ifdef SYNC_COUNTER_MATCH_EN
        chk("a_match", 32'(a_match), 32'(ma.match));
`endif
      end
      if (vb) begin
        chk("b_q",    32'(b_q),    32'(mb.q));
        chk("b_rco",  32'(b_rco),  32'(b_ent && mtc(mb.q, b_up, 16) && !mb.halted));
        chk("b_done", 32'(b_done), 32'(mb.halted));
`ifdef SYNC_COUNTER_MATCH_EN
        chk("b_match", 32'(b_match), 32'(mb.match));
`endif
      end
      if (vc) begin
        chk("c_q",      32'({c_hi_q, c_lo_q}), 32'(mc));
        chk("c_lo_rco", 32'(c_lo_rco), 32'(c_en && (mc % 16) == 15));
      end
    end
  end

  // ---------------- stimulus + hand-computed expectations ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    a_rst = 1; a_clr = 1; a_load = 1; a_enp = 0; a_ent = 0; a_up = 1; a_d = 0;
    b_rst = 1; b_clr = 1; b_load = 1; b_enp = 0; b_ent = 0; b_up = 1; b_d = 0;
    c_rst = 1; c_clr = 1; c_load = 1; c_en = 0; c_d = 0;
`ifdef SYNC_COUNTER_MATCH_EN
    a_mv = 4'd7; b_mv = 4'd15;
`endif
    step();
    chk("rst_a_q",    32'(a_q),    32'd5);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_rco",  32'(a_rco),  32'd0);
    chk("rst_b_q",    32'(b_q),    32'd0);
    chk("rst_c_q",    32'({c_hi_q, c_lo_q}), 32'd0);
    a_rst = 0; b_rst = 0; c_rst = 0;

    a_load = 0; a_d = 4'hE;
    step();
    chk("load_a_q", 32'(a_q), 32'd14);
    a_clr = 0; a_d = 4'd3;
    step();
    chk("clr_over_load", 32'(a_q), 32'd0);

    a_clr = 1; a_load = 1; a_enp = 1; a_ent = 1; a_up = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("upwrap_q",   32'(a_q),   32'((i + 1) % 10));
      chk("upwrap_rco", 32'(a_rco), 32'(((i + 1) % 10) == 9));
`ifdef SYNC_COUNTER_MATCH_EN
      chk("match_pulse", 32'(a_match), 32'(((i + 1) % 10) == 7));
`endif
    end

    a_load = 0; a_d = 4'd1; a_up = 0;
    step();
    chk("load_wins", 32'(a_q), 32'd1);
    a_load = 1;
    step();
    chk("down_q0",   32'(a_q),   32'd0);
    chk("down_rco0", 32'(a_rco), 32'd1);
    step();
    chk("down_wrap", 32'(a_q), 32'd9);
    step();
    chk("down_q8", 32'(a_q), 32'd8);
    a_enp = 0;
    step();
    chk("enp_hold", 32'(a_q), 32'd8);
    a_load = 0; a_d = 4'd0;
    step();
    a_load = 1;
    chk("ld0_q",   32'(a_q),   32'd0);
    chk("ld0_rco", 32'(a_rco), 32'd1);
    a_enp = 1; a_ent = 0;
    step();
    chk("ent_hold",   32'(a_q),   32'd0);
    chk("ent_rco_lo", 32'(a_rco), 32'd0);

    b_load = 0; b_d = 4'd14;
    step();
    b_load = 1; b_enp = 1; b_ent = 1; b_up = 1;
    step();
    chk("os_q15",   32'(b_q),    32'd15);
    chk("os_done0", 32'(b_done), 32'd0);
    chk("os_rco1",  32'(b_rco),  32'd1);
    step();
    chk("os_halt_q",    32'(b_q),    32'd15);
    chk("os_halt_done", 32'(b_done), 32'd1);
    chk("os_halt_rco",  32'(b_rco),  32'd0);
    step();
    chk("os_stay_q", 32'(b_q), 32'd15);
    b_load = 0; b_d = 4'd3;
    step();
    b_load = 1;
    chk("os_reload_q",    32'(b_q),    32'd3);
    chk("os_reload_done", 32'(b_done), 32'd0);

    c_clr = 0;
    step();
    c_clr = 1; c_en = 1;
    for (int i = 0; i < 255; i++) step();
    chk("casc_ff", 32'({c_hi_q, c_lo_q}), 32'd255);
    step();
    chk("casc_00", 32'({c_hi_q, c_lo_q}), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      a_rst  = ($urandom_range(0, 63) == 0);
      a_clr  = ($urandom_range(0, 15) != 0);
      a_load = ($urandom_range(0, 9) != 0);
      a_enp  = ($urandom_range(0, 3) != 0);
      a_ent  = ($urandom_range(0, 3) != 0);
      a_up   = 1'($urandom_range(0, 1));
      a_d    = 4'($urandom_range(0, 15));
      b_rst  = ($urandom_range(0, 99) == 0);
      b_clr  = ($urandom_range(0, 39) != 0);
      b_load = ($urandom_range(0, 19) != 0);
      b_enp  = ($urandom_range(0, 3) != 0);
      b_ent  = ($urandom_range(0, 3) != 0);
      b_up   = 1'($urandom_range(0, 1));
      b_d    = 4'($urandom_range(0, 15));
      c_rst  = ($urandom_range(0, 199) == 0);
      c_clr  = ($urandom_range(0, 99) != 0);
      c_load = ($urandom_range(0, 49) != 0);
      c_en   = ($urandom_range(0, 3) != 0);
      c_d    = 8'($urandom_range(0, 255));
`ifdef SYNC_COUNTER_MATCH_EN
      if ($urandom_range(0, 15) == 0) a_mv = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) b_mv = 4'($urandom_range(0, 15));
`endif
      step();
    end

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
